// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - Boot-time loader that writes a framed, checksummed byte stream into instruction memory.
// Frame: LEN_LO, LEN_HI, L payload bytes, then one checksum byte (payload sum mod 256).
module imem_loader #(
    parameter int INST_MEMORY_SIZE = 1024,
    parameter int ADDR_WIDTH       = $clog2(INST_MEMORY_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cpu_stall
);

    localparam int          DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [7:0]            sum_q, sum_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            wdata_q, wdata_d;

    logic                  accept;
    logic [15:0]           len_full;
    logic [ADDR_WIDTH:0]   cnt_inc;

    assign accept   = in_valid && in_ready;
    assign len_full = {in_data, len_q[7:0]};
    assign cnt_inc  = cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                // A byte presented alongside start is never accepted: in_ready is low here.
                if (start) begin
                    state_d = S_LEN_LO;
                    len_d   = '0;
                    cnt_d   = '0;
                    sum_d   = '0;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = in_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d = len_full;
                    // Word-multiple, non-empty and within capacity, so the address never wraps.
                    if ((len_full == 16'd0) || (len_full[1:0] != 2'b00) ||
                        ({1'b0, len_full} > DEPTH_L)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q[ADDR_WIDTH-1:0];
                    wdata_d = in_data;
                    sum_d   = sum_q + in_data;
                    cnt_d   = cnt_inc;
                    if (17'(cnt_inc) == {1'b0, len_q}) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (accept) begin
                    state_d = (in_data == sum_q) ? S_DONE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                       (state_q == S_DATA)   || (state_q == S_CHECK);
    assign busy      = in_ready;
    assign done      = (state_q == S_DONE);
    assign error     = (state_q == S_ERR);
    // Only a fully verified image releases the CPU.
    assign cpu_stall = (state_q != S_DONE);

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - Self-checking bench for imem_loader with a frame-level reference model.
module tb_imem_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          busy;
    logic          done;
    logic          error;
    logic          cpu_stall;

    int checks = 0;
    int errors = 0;

    logic [7:0]    frame[$];
    logic [AW+7:0] exp_q[$];
    logic [AW+7:0] obs_q[$];
    int            n_send;
    bit            exp_done;
    bit            exp_err;

    logic [7:0] good_frame [11] = '{8'h08, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                                    8'h93, 8'h05, 8'h20, 8'h00, 8'hE0};

    imem_loader #(.INST_MEMORY_SIZE(1024)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error), .cpu_stall(cpu_stall)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) obs_q.push_back({mem_addr, mem_wdata});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit st);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        start    = st;
        for (int k = 0; k < 32 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    // Reference: decide the outcome of the frame directly from its byte list.
    task automatic model_frame();
        int  len;
        int  sum;
        bit  legal;
        len   = int'(frame[0]) + 256 * int'(frame[1]);
        legal = (len != 0) && (len % 4 == 0) && (len <= 1024);
        exp_q.delete();
        if (legal) begin
            sum = 0;
            for (int i = 0; i < len; i++) begin
                exp_q.push_back({10'(i), frame[2+i]});
                sum += int'(frame[2+i]);
            end
            n_send   = len + 3;
            exp_done = (int'(frame[2+len]) == (sum % 256));
            exp_err  = !exp_done;
        end else begin
            n_send   = 2;
            exp_done = 1'b0;
            exp_err  = 1'b1;
        end
    endtask

    task automatic build_random(input int len, input int corrupt);
        int sum;
        logic [7:0] b;
        frame.delete();
        frame.push_back(8'(len));
        frame.push_back(8'(len >> 8));
        sum = 0;
        if (len <= 1024) begin
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom);
                frame.push_back(b);
                sum += int'(b);
            end
        end
        frame.push_back(8'(sum + corrupt));
    endtask

    task automatic load_good();
        frame.delete();
        foreach (good_frame[i]) frame.push_back(good_frame[i]);
    endtask

    task automatic check_results(input string tag);
        int n;
        check({tag, "_nwrites"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_write"}, 32'(obs_q[i]), 32'(exp_q[i]));
        check({tag, "_done"},      done,      exp_done);
        check({tag, "_error"},     error,     exp_err);
        check({tag, "_busy"},      busy,      1'b0);
        check({tag, "_cpu_stall"}, cpu_stall, !exp_done);
        check({tag, "_in_ready"},  in_ready,  1'b0);
        check({tag, "_mem_we"},    mem_we,    1'b0);
    endtask

    task automatic start_pulse();
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int gap_mode, input int start_at);
        model_frame();
        obs_q.delete();
        start_pulse();
        for (int i = 0; i < n_send; i++) begin
            if (gap_mode == 1 && i > 0) idle(1);
            else if (gap_mode == 2) idle(int'($urandom_range(0, 2)));
            send_byte(frame[i], (i == start_at));
        end
        idle(3);
        check_results(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  in_ready,  1'b0);
        check({tag, "_mem_we"},    mem_we,    1'b0);
        check({tag, "_mem_addr"},  mem_addr,  '0);
        check({tag, "_mem_wdata"}, mem_wdata, 8'h00);
        check({tag, "_busy"},      busy,      1'b0);
        check({tag, "_done"},      done,      1'b0);
        check({tag, "_error"},     error,     1'b0);
        check({tag, "_cpu_stall"}, cpu_stall, 1'b1);
    endtask

    initial begin
        int len;
        int sel;
        int illegal_lens [6] = '{0, 2, 5, 1028, 1030, 2000};

        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Data offered in IDLE without start must be ignored.
        obs_q.delete();
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (4) begin
            @(negedge clk);
            check("idle_in_ready", in_ready, 1'b0);
        end
        idle(1);
        check("idle_nwrites", obs_q.size(), 0);
        check("idle_busy", busy, 1'b0);

        load_good();
        run_frame("good", 0, -1);

        load_good();
        frame[10] = 8'hE1;
        run_frame("badsum", 0, -1);

        frame.delete();
        frame.push_back(8'h06);
        frame.push_back(8'h00);
        run_frame("len6", 0, -1);
        load_good();
        run_frame("good_after_len6", 0, -1);

        frame.delete();
        frame.push_back(8'h04);
        frame.push_back(8'h04);
        run_frame("len1028", 0, -1);
        load_good();
        run_frame("good_after_len1028", 0, -1);

        load_good();
        run_frame("gaps", 1, -1);

        // Asynchronous reset in the middle of the payload.
        load_good();
        obs_q.delete();
        start_pulse();
        for (int i = 0; i < 5; i++) send_byte(frame[i], 1'b0);
        check("pre_rst_we", mem_we, 1'b1);
        check("pre_rst_addr", mem_addr, 10'd2);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        load_good();
        run_frame("good_after_rst", 0, -1);

        load_good();
        run_frame("start_busy", 0, 5);

        build_random(1024, 0);
        run_frame("len1024", 2, -1);

        for (int it = 0; it < 12; it++) begin
            sel = int'($urandom_range(0, 4));
            if (sel == 0) len = illegal_lens[$urandom_range(0, 5)];
            else          len = 4 * int'($urandom_range(1, 24));
            build_random(len, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 255)) : 0);
            run_frame("random", int'($urandom_range(0, 2)),
                      ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 30)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
